fifo_axis_reader: RTL

FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

---
 rtl/fifo_axis_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/fifo_axis_reader.sv | 118 +++++++++++
 3 files changed

// File: rtl/fifo_axis_pkg.sv
// ============================================================================
// Module   : fifo_axis_pkg
// Purpose  : Shared state encoding and constant log2 helper for the FIFO reader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Ceiling log2, usable in constant expressions; returns at least 1.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO used as upstream source.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo
    import fifo_axis_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int C_AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW:0]    r_wr_ptr;
    logic [C_AW:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit distinguishes full from empty when addresses match.
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                    (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;
    assign dout   = r_mem[r_rd_ptr[C_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (C_AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (C_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[C_AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/fifo_axis_reader.sv
// ============================================================================
// Module   : fifo_axis_reader
// Purpose  : Drains xfer_len words from a FWFT FIFO as BURST_LEN-beat AXIS packets.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_axis_reader
    import fifo_axis_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 32,
    parameter int BURST_LEN      = 16,
    parameter int LEN_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LEN_W-1:0]          xfer_len,
    output logic                      busy,
    output logic                      done,
    output logic                      fifo_rd_en,
    input  logic [DATA_BUS_WIDTH-1:0] fifo_dout,
    input  logic                      fifo_empty,
    output logic [DATA_BUS_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast
);

    localparam int                C_BEAT_W    = clog2(BURST_LEN);
    localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(BURST_LEN - 1);

    state_t                    r_state;
    logic [LEN_W-1:0]          r_remaining;
    logic [C_BEAT_W-1:0]       r_beat;
    logic [DATA_BUS_WIDTH-1:0] r_tdata;
    logic                      r_tvalid;
    logic                      r_tlast;
    logic                      r_busy;
    logic                      r_done;
    logic                      w_load;
    logic                      w_load_last;

    // A word moves into the output register whenever it is empty or draining.
    assign w_load      = (r_state == ST_RUN) && !fifo_empty && (!r_tvalid || m_axis_tready);
    assign w_load_last = (r_beat == C_LAST_BEAT) || (r_remaining == LEN_W'(1));

    assign fifo_rd_en    = w_load;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_beat      <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_load) begin
                r_tdata     <= fifo_dout;
                r_tvalid    <= 1'b1;
                r_tlast     <= w_load_last;
                r_remaining <= r_remaining - LEN_W'(1);
                r_beat      <= w_load_last ? '0 : r_beat + C_BEAT_W'(1);
            end else if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        if (xfer_len != '0) begin
                            r_remaining <= xfer_len;
                            r_beat      <= '0;
                            r_state     <= ST_RUN;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_load && (r_remaining == LEN_W'(1))) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    // Only the final beat can be pending here.
                    if (r_tvalid && m_axis_tready) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
